// File: rtl/l2_flush_ctrl_pkg.sv
// rtl/l2_flush_ctrl_pkg.sv - shared types and defaults for the L2 flush sequencer
//
// Purpose: holds the flush FSM state encoding and default L2 geometry.
// These defaults match the spandex L2 set/way constants.
// Ports: none (package).

package l2_flush_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ISSUE,
    ST_WAIT,
    ST_ACKWAIT,
    ST_DONE
  } l2_flush_state_t;

  localparam int L2_SETS_DEF = 256;
  localparam int L2_WAYS_DEF = 8;

endpackage

// File: rtl/l2_flush_ctrl_if.sv
// rtl/l2_flush_ctrl_if.sv - flush request / per-line evict bundle between flush ctrl and l2_fsm
//
// Purpose: groups the flush request handshake, the evict command channel and
// the flush status signals.
// Modports:
//   master - the flush controller. It drives ready, evict command, status and done.
//   slave  - the L2 side. It drives flush request, evict_ready, evict_done and mshr_cnt_zero.

interface l2_flush_ctrl_if #(
  parameter int SET_BITS = 8,
  parameter int WAY_BITS = 3
);
  logic                l2_flush_valid;
  logic                l2_flush_i;
  logic                l2_flush_ready;
  logic                evict_valid;
  logic                evict_ready;
  logic [SET_BITS-1:0] evict_set;
  logic [WAY_BITS-1:0] evict_way;
  logic                is_flush_all;
  logic                evict_done;
  logic                mshr_cnt_zero;
  logic                ongoing_flush;
  logic                flush_done;

  modport master (
    input  l2_flush_valid, l2_flush_i, evict_ready, evict_done, mshr_cnt_zero,
    output l2_flush_ready, evict_valid, evict_set, evict_way, is_flush_all,
           ongoing_flush, flush_done
  );

  modport slave (
    output l2_flush_valid, l2_flush_i, evict_ready, evict_done, mshr_cnt_zero,
    input  l2_flush_ready, evict_valid, evict_set, evict_way, is_flush_all,
           ongoing_flush, flush_done
  );
endinterface

// File: rtl/l2_flush_cnt.sv
// rtl/l2_flush_cnt.sv - nested set/way walk counter with last-line flag
//
// Purpose: walks (set, way) in order: way is the inner index and set is the outer index.
// It is reusable by any whole-cache walker.
// Ports:
//   clk, rst        clock, async active-high reset
//   clr             restart the walk at (0,0)
//   adv             step to the next line
//   set_idx/way_idx current line
//   last            current line is (SETS-1, WAYS-1)

module l2_flush_cnt #(
  parameter int SETS     = 256,
  parameter int WAYS     = 8,
  parameter int SET_BITS = $clog2(SETS),
  parameter int WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                adv,
  output logic [SET_BITS-1:0] set_idx,
  output logic [WAY_BITS-1:0] way_idx,
  output logic                last
);

  // One spare bit on each counter means stepping past the final line yields
  // SETS rather than aliasing back to set 0.
  localparam logic [SET_BITS:0] SET_LAST = (SET_BITS+1)'(SETS - 1);
  localparam logic [WAY_BITS:0] WAY_LAST = (WAY_BITS+1)'(WAYS - 1);

  logic [SET_BITS:0] set_q;
  logic [WAY_BITS:0] way_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q <= '0;
      way_q <= '0;
    end else if (clr) begin
      set_q <= '0;
      way_q <= '0;
    end else if (adv) begin
      if (way_q == WAY_LAST) begin
        way_q <= '0;
        set_q <= set_q + 1'b1;
      end else begin
        way_q <= way_q + 1'b1;
      end
    end
  end

  assign last    = (set_q == SET_LAST) && (way_q == WAY_LAST);
  assign set_idx = set_q[SET_BITS-1:0];
  assign way_idx = way_q[WAY_BITS-1:0];

endmodule

// File: rtl/l2_flush_ctrl.sv
// rtl/l2_flush_ctrl.sv - L2 flush sequencer: walks every line through l2_fsm, then drains MSHRs
//
// Purpose: accepts one flush and drains in-flight misses. It then issues one
// evict command per (set, way) in order, waiting for evict_done after each.
// Finally it waits for the writebacks to be acked and pulses flush_done.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       l2_flush_ctrl_if master side: the flush request handshake, the evict command channel,
//             evict_done, mshr_cnt_zero, and the status outputs
//             ongoing_flush, is_flush_all and flush_done
// Every output is decoded from registered state only.

module l2_flush_ctrl
  import l2_flush_ctrl_pkg::*;
#(
  parameter int L2_SETS  = L2_SETS_DEF,
  parameter int L2_WAYS  = L2_WAYS_DEF,
  parameter int SET_BITS = $clog2(L2_SETS),
  parameter int WAY_BITS = $clog2(L2_WAYS)
) (
  input logic             clk,
  input logic             rst,
  l2_flush_ctrl_if.master bus
);

  l2_flush_state_t     state_q;
  l2_flush_state_t     state_d;
  logic                flush_all_q;
  logic                accept;
  logic                cnt_adv;
  logic                cnt_last;
  logic [SET_BITS-1:0] cnt_set;
  logic [WAY_BITS-1:0] cnt_way;

  logic o_ready;
  logic o_valid;
  logic o_ongoing;
  logic o_done;

  assign accept  = (state_q == ST_IDLE) && bus.l2_flush_valid;
  // evict_done is only meaningful while waiting on a line.
  assign cnt_adv = (state_q == ST_WAIT) && bus.evict_done;

  l2_flush_cnt #(
    .SETS     (L2_SETS),
    .WAYS     (L2_WAYS),
    .SET_BITS (SET_BITS),
    .WAY_BITS (WAY_BITS)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .adv     (cnt_adv),
    .set_idx (cnt_set),
    .way_idx (cnt_way),
    .last    (cnt_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_all_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) flush_all_q <= bus.l2_flush_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.l2_flush_valid) state_d = ST_DRAIN;
      ST_DRAIN:   if (bus.mshr_cnt_zero)  state_d = ST_ISSUE;
      ST_ISSUE:   if (bus.evict_ready)    state_d = ST_WAIT;
      // cnt_last still refers to the line just completed, because the counter
      // advances on this same edge.
      ST_WAIT:    if (bus.evict_done)     state_d = cnt_last ? ST_ACKWAIT : ST_ISSUE;
      ST_ACKWAIT: if (bus.mshr_cnt_zero)  state_d = ST_DONE;
      ST_DONE:                            state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_ongoing = 1'b1;
    o_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready   = 1'b1;
        o_ongoing = 1'b0;
      end
      ST_ISSUE: o_valid = 1'b1;
      ST_DONE:  o_done  = 1'b1;
      default: ;
    endcase
  end

  assign bus.l2_flush_ready = o_ready;
  assign bus.evict_valid    = o_valid;
  assign bus.evict_set      = cnt_set;
  assign bus.evict_way      = cnt_way;
  assign bus.is_flush_all   = flush_all_q;
  assign bus.ongoing_flush  = o_ongoing;
  assign bus.flush_done     = o_done;

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// tb/tb_l2_flush_ctrl.sv - self-checking bench for l2_flush_ctrl (4 sets x 2 ways)

module tb_l2_flush_ctrl;

  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int NV   = 21;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cmd_count = 0;
  int   done_count = 0;

  l2_flush_ctrl_if #(.SET_BITS(2), .WAY_BITS(1)) bus ();

  l2_flush_ctrl #(.L2_SETS(SETS), .L2_WAYS(WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.evict_valid && bus.evict_ready) cmd_count <= cmd_count + 1;
    if (bus.flush_done) done_count <= done_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic fv, fi, er, ed, mz;
    logic e_rdy, e_val, e_ong, e_done, e_ifa;
    int   e_set, e_way;
  } vec_t;

  vec_t tbl [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic serve_line(input int s, input int w, input int stall, input bit drop_mshr);
    int n;
    n = 0;
    while (bus.evict_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("issue_wait", int'(n < 40), 1);
    chk("cmd_set", int'(bus.evict_set), s);
    chk("cmd_way", int'(bus.evict_way), w);
    chk("busy_ready", int'(bus.l2_flush_ready), 0);
    chk("busy_ongoing", int'(bus.ongoing_flush), 1);
    for (int i = 1; i < stall; i++) begin
      tick();
      chk("stall_valid", int'(bus.evict_valid), 1);
      chk("stall_set", int'(bus.evict_set), s);
      chk("stall_way", int'(bus.evict_way), w);
    end
    bus.evict_ready = 1'b1;
    tick();
    bus.evict_ready = 1'b0;
    chk("post_hs_valid", int'(bus.evict_valid), 0);
    bus.evict_done = 1'b1;
    if (drop_mshr) bus.mshr_cnt_zero = 1'b0;
    tick();
    bus.evict_done = 1'b0;
  endtask

  task automatic walk(input int ss, input int sw, input int sn, input bit drop_last);
    int c0;
    int b;
    c0 = cmd_count;
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        b = cmd_count;
        serve_line(s, w, (s == ss && w == sw) ? sn : 0,
                   drop_last && s == SETS-1 && w == WAYS-1);
        if (s == ss && w == sw) chk("stall_one_cmd", cmd_count - b, 1);
      end
    end
    chk("walk_cmds", cmd_count - c0, SETS*WAYS);
  endtask

  task automatic finish_flush();
    int d0;
    d0 = done_count;
    chk("ack_ongoing", int'(bus.ongoing_flush), 1);
    chk("ack_done", int'(bus.flush_done), 0);
    tick();
    chk("done_pulse", int'(bus.flush_done), 1);
    tick();
    chk("done_clear", int'(bus.flush_done), 0);
    chk("idle_ready", int'(bus.l2_flush_ready), 1);
    chk("idle_ongoing", int'(bus.ongoing_flush), 0);
    chk("done_count", done_count - d0, 1);
  endtask

  task automatic start_flush(input logic fi);
    bus.l2_flush_valid = 1'b1;
    bus.l2_flush_i     = fi;
    chk("start_ready", int'(bus.l2_flush_ready), 1);
    tick();
    bus.l2_flush_valid = 1'b0;
    chk("start_ongoing", int'(bus.ongoing_flush), 1);
    chk("start_ifa", int'(bus.is_flush_all), int'(fi));
  endtask

  initial begin
    int c0;
    int d0;

    for (int c = 0; c < NV; c++) begin
      tbl[c] = '{fv: 1'b0, fi: 1'b0, er: 1'b0, ed: 1'b0, mz: 1'b1,
                 e_rdy: 1'b0, e_val: 1'b0, e_ong: 1'b1, e_done: 1'b0, e_ifa: 1'b1,
                 e_set: 0, e_way: 0};
    end
    tbl[0].fv = 1'b1; tbl[0].fi = 1'b1;
    tbl[0].e_rdy = 1'b1; tbl[0].e_ong = 1'b0; tbl[0].e_ifa = 1'b0;
    for (int i = 0; i < SETS*WAYS; i++) begin
      tbl[2+2*i].er    = 1'b1;
      tbl[2+2*i].e_val = 1'b1;
      tbl[2+2*i].e_set = i / WAYS;
      tbl[2+2*i].e_way = i % WAYS;
      tbl[3+2*i].ed    = 1'b1;
    end
    tbl[19].e_done = 1'b1;
    tbl[20].e_rdy = 1'b1; tbl[20].e_ong = 1'b0;

    rst = 1'b1;
    bus.l2_flush_valid = 1'b0;
    bus.l2_flush_i     = 1'b0;
    bus.evict_ready    = 1'b0;
    bus.evict_done     = 1'b0;
    bus.mshr_cnt_zero  = 1'b1;
    tick();
    tick();
    chk("rst_ready", int'(bus.l2_flush_ready), 1);
    chk("rst_valid", int'(bus.evict_valid), 0);
    chk("rst_ongoing", int'(bus.ongoing_flush), 0);
    chk("rst_done", int'(bus.flush_done), 0);
    chk("rst_ifa", int'(bus.is_flush_all), 0);
    rst = 1'b0;
    tick();

    // Full flush, cycle by cycle.
    c0 = cmd_count;
    d0 = done_count;
    for (int c = 0; c < NV; c++) begin
      bus.l2_flush_valid = tbl[c].fv;
      bus.l2_flush_i     = tbl[c].fi;
      bus.evict_ready    = tbl[c].er;
      bus.evict_done     = tbl[c].ed;
      bus.mshr_cnt_zero  = tbl[c].mz;
      chk($sformatf("v%0d_ready", c), int'(bus.l2_flush_ready), int'(tbl[c].e_rdy));
      chk($sformatf("v%0d_valid", c), int'(bus.evict_valid), int'(tbl[c].e_val));
      chk($sformatf("v%0d_ongoing", c), int'(bus.ongoing_flush), int'(tbl[c].e_ong));
      chk($sformatf("v%0d_done", c), int'(bus.flush_done), int'(tbl[c].e_done));
      chk($sformatf("v%0d_ifa", c), int'(bus.is_flush_all), int'(tbl[c].e_ifa));
      if (tbl[c].e_val) begin
        chk($sformatf("v%0d_set", c), int'(bus.evict_set), tbl[c].e_set);
        chk($sformatf("v%0d_way", c), int'(bus.evict_way), tbl[c].e_way);
      end
      tick();
    end
    bus.l2_flush_valid = 1'b0;
    bus.evict_ready    = 1'b0;
    bus.evict_done     = 1'b0;
    chk("tbl_cmds", cmd_count - c0, SETS*WAYS);
    chk("tbl_dones", done_count - d0, 1);

    // DRAIN holds off the walk until MSHRs are empty; stall at (2,1).
    bus.mshr_cnt_zero = 1'b0;
    start_flush(1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("drain_valid", int'(bus.evict_valid), 0);
      chk("drain_ongoing", int'(bus.ongoing_flush), 1);
      tick();
    end
    bus.mshr_cnt_zero = 1'b1;
    chk("drain_last_valid", int'(bus.evict_valid), 0);
    tick();
    chk("drain_exit_valid", int'(bus.evict_valid), 1);
    walk(2, 1, 5, 1'b0);
    finish_flush();

    // Second request held during the walk and accepted right after flush_done.
    bus.l2_flush_valid = 1'b1;
    bus.l2_flush_i     = 1'b1;
    tick();
    bus.l2_flush_i = 1'b0;
    chk("held_ifa1", int'(bus.is_flush_all), 1);
    walk(-1, -1, 0, 1'b0);
    chk("held_ack_ready", int'(bus.l2_flush_ready), 0);
    tick();
    chk("held_done", int'(bus.flush_done), 1);
    chk("held_done_ready", int'(bus.l2_flush_ready), 0);
    tick();
    chk("held_idle_ready", int'(bus.l2_flush_ready), 1);
    chk("held_idle_ifa", int'(bus.is_flush_all), 1);
    tick();
    bus.l2_flush_valid = 1'b0;
    chk("held_accept_ongoing", int'(bus.ongoing_flush), 1);
    chk("held_ifa0", int'(bus.is_flush_all), 0);

    // MSHRs busy after the last line: ACKWAIT holds until they drain.
    walk(-1, -1, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("ackwait_done", int'(bus.flush_done), 0);
      chk("ackwait_ongoing", int'(bus.ongoing_flush), 1);
      chk("ackwait_valid", int'(bus.evict_valid), 0);
      tick();
    end
    bus.mshr_cnt_zero = 1'b1;
    chk("ackwait_rise_done", int'(bus.flush_done), 0);
    tick();
    chk("ackwait_done_pulse", int'(bus.flush_done), 1);
    tick();
    chk("ackwait_done_clear", int'(bus.flush_done), 0);
    chk("ackwait_idle_ready", int'(bus.l2_flush_ready), 1);

    // Asynchronous reset at command (1,0), then a fresh flush from (0,0).
    start_flush(1'b1);
    serve_line(0, 0, 0, 1'b0);
    serve_line(0, 1, 0, 1'b0);
    chk("pre_rst_valid", int'(bus.evict_valid), 1);
    chk("pre_rst_set", int'(bus.evict_set), 1);
    chk("pre_rst_way", int'(bus.evict_way), 0);
    d0 = done_count;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.evict_valid), 0);
    chk("arst_ongoing", int'(bus.ongoing_flush), 0);
    chk("arst_ready", int'(bus.l2_flush_ready), 1);
    chk("arst_ifa", int'(bus.is_flush_all), 0);
    chk("arst_set", int'(bus.evict_set), 0);
    chk("arst_done", int'(bus.flush_done), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_no_done", done_count - d0, 0);
    start_flush(1'b0);
    walk(-1, -1, 0, 1'b0);
    finish_flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
